multdiv_sequencer: RTL and testbench

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer_pkg.sv | 34 +++
 rtl/md_watchdog.sv | 44 ++++
 rtl/multdiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_multdiv_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// ============================================================
// multdiv_sequencer_pkg: decode constants, status codes and state encoding.
// Rev 1.0
// ============================================================
`default_nettype none

package multdiv_sequencer_pkg;

  localparam logic [4:0]  OPC_R      = 5'd0;
  localparam logic [4:0]  FUNC_MUL   = 5'd6;
  localparam logic [4:0]  FUNC_DIV   = 5'd7;
  localparam logic [4:0]  RSTATUS    = 5'd30;
  localparam logic [31:0] STATUS_MUL = 32'd4;
  localparam logic [31:0] STATUS_DIV = 32'd5;
  localparam int          CNT_W      = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Watchdog limits larger than the counter range clamp to its saturation value.
  function automatic logic [CNT_W-1:0] sat_limit(input int unsigned cycles);
    if (cycles > 32'd63) begin
      return 6'd63;
    end
    return cycles[CNT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_watchdog.sv
// ============================================================
// md_watchdog: saturating RUN-cycle counter with limit comparison.
// Rev 1.0
// ============================================================
`default_nettype none

module md_watchdog
  import multdiv_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expires on the cycle whose increment makes the count reach the limit.
  assign expired_o = enable_i &&
                     (({1'b0, count_q} + 7'd1) >= {1'b0, limit_i});

endmodule

`default_nettype wire

// File: rtl/multdiv_sequencer.sv
// ============================================================
// multdiv_sequencer: issues mul/div start pulses, stalls the front end and
// writes back either the unit result or an exception code to $r30.  Rev 1.0
// ============================================================
`default_nettype none

module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 17,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned SLACK      = 4
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  opCode,
  input  logic [4:0]  funcode,
  input  logic [4:0]  rd,
  input  logic        unit_rdy,
  input  logic        unit_exception,
  input  logic        flush,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic        wb_status,
  output logic [31:0] wb_status_val
);

  localparam logic [CNT_W-1:0] MUL_LIMIT = sat_limit(MUL_CYCLES + SLACK);
  localparam logic [CNT_W-1:0] DIV_LIMIT = sat_limit(DIV_CYCLES + SLACK);

  state_e     state_q, state_d;
  logic [4:0] rd_q, rd_d;
  logic       op_q, op_d;   // 1 = divide
  logic       exc_q, exc_d;

  logic       hit;
  logic       wd_clear;
  logic       wd_en;
  logic       wd_expired;

  assign hit = issue_valid && (opCode == OPC_R) &&
               ((funcode == FUNC_MUL) || (funcode == FUNC_DIV));

  md_watchdog u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .limit_i   (op_q ? DIV_LIMIT : MUL_LIMIT),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    op_d          = op_q;
    exc_d         = exc_q;
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    stall         = 1'b0;
    wb_en         = 1'b0;
    wb_reg        = 5'd0;
    wb_status     = 1'b0;
    wb_status_val = 32'd0;
    wd_clear      = 1'b0;
    wd_en         = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = hit;
        if (hit && !flush) begin
          state_d = S_START;
          rd_d    = rd;
          op_d    = (funcode == FUNC_DIV);
          exc_d   = 1'b0;
        end
      end
      S_START: begin
        stall    = 1'b1;
        wd_clear = 1'b1;
        state_d  = S_RUN;
        if (!flush) begin
          ctrl_mult = !op_q;
          ctrl_div  = op_q;
        end
      end
      S_RUN: begin
        stall = 1'b1;
        wd_en = 1'b1;
        // A ready unit wins over a watchdog expiry in the same cycle.
        if (unit_rdy) begin
          state_d = S_DONE;
          exc_d   = unit_exception;
        end else if (wd_expired) begin
          state_d = S_DONE;
          exc_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (exc_q) begin
            wb_en         = 1'b1;
            wb_reg        = RSTATUS;
            wb_status     = 1'b1;
            wb_status_val = op_q ? STATUS_DIV : STATUS_MUL;
          end else begin
            wb_en  = (rd_q != 5'd0);
            wb_reg = rd_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= 5'd0;
      op_q    <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      exc_q   <= exc_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
// ============================================================
// tb_multdiv_sequencer: scoreboard bench for the mul/div issue sequencer.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  opCode;
  logic [4:0]  funcode;
  logic [4:0]  rd;
  logic        unit_rdy;
  logic        unit_exception;
  logic        flush;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic        wb_status;
  logic [31:0] wb_status_val;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .opCode         (opCode),
    .funcode        (funcode),
    .rd             (rd),
    .unit_rdy       (unit_rdy),
    .unit_exception (unit_exception),
    .flush          (flush),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .stall          (stall),
    .busy           (busy),
    .wb_en          (wb_en),
    .wb_reg         (wb_reg),
    .wb_status      (wb_status),
    .wb_status_val  (wb_status_val)
  );

  typedef struct {
    logic [4:0]  r;
    logic        st;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_mult = 0;
  int n_div = 0;
  int n_wb = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int stall_run = 0;
  int last_stall_run = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: pulse bookkeeping and writeback comparison.
  always @(negedge clock) begin
    if (ctrl_mult) begin
      n_mult = n_mult + 1;
      start_cyc = cyc;
    end
    if (ctrl_div) begin
      n_div = n_div + 1;
      start_cyc = cyc;
    end
    if (busy && !stall) done_cyc = cyc;
    if (stall) begin
      stall_run = stall_run + 1;
    end else begin
      if (stall_run > 0) last_stall_run = stall_run;
      stall_run = 0;
    end
    if (wb_en) begin
      n_wb = n_wb + 1;
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_wb: got reg=%0d status=%0b val=%0d, expected no writeback",
                 wb_reg, wb_status, wb_status_val);
      end else begin
        mon_e = q.pop_front();
        if ({wb_reg, wb_status, wb_status_val} !== {mon_e.r, mon_e.st, mon_e.val}) begin
          errors = errors + 1;
          $display("FAIL wb_data: got reg=%0d status=%0b val=%0d, expected reg=%0d status=%0b val=%0d",
                   wb_reg, wb_status, wb_status_val, mon_e.r, mon_e.st, mon_e.val);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input bit is_div, input logic [4:0] r);
    issue_valid = 1'b1;
    opCode      = 5'd0;
    funcode     = is_div ? 5'd7 : 5'd6;
    rd          = r;
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic pulse_rdy(input bit exc);
    unit_rdy       = 1'b1;
    unit_exception = exc;
    @(posedge clock);
    #1;
    unit_rdy       = 1'b0;
    unit_exception = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; unit_rdy = 1'b0; unit_exception = 1'b0;
    issue_valid = 1'b1; opCode = 5'd0; funcode = 5'd6; rd = 5'd3;
    @(negedge clock);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL reset_stall_hit: got %0b, expected 1", stall);
    end
    checks++;
    if ({ctrl_mult, ctrl_div, busy, wb_en, wb_reg, wb_status, wb_status_val} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cm=%0b cd=%0b busy=%0b wb_en=%0b reg=%0d st=%0b val=%0d, expected all 0",
               ctrl_mult, ctrl_div, busy, wb_en, wb_reg, wb_status, wb_status_val);
    end
    issue_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall_nohit: got %0b, expected 0", stall);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_mul_basic();
    int m0, d0;
    bit ok;
    m0 = n_mult; d0 = n_div;
    q.push_back('{5'd3, 1'b0, 32'd0});
    issue(1'b0, 5'd3);
    wait_cycles(17);
    pulse_rdy(1'b0);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mul_idle_timeout: busy=%0b, expected 0", busy); end
    checks++;
    if (n_mult - m0 !== 1) begin errors++; $display("FAIL mul_pulses: got %0d, expected 1", n_mult - m0); end
    checks++;
    if (n_div - d0 !== 0) begin errors++; $display("FAIL mul_div_pulses: got %0d, expected 0", n_div - d0); end
    checks++;
    if (done_cyc - start_cyc !== 18) begin
      errors++; $display("FAIL mul_latency: got %0d, expected 18", done_cyc - start_cyc);
    end
    checks++;
    if (last_stall_run !== 19) begin
      errors++; $display("FAIL mul_stall_len: got %0d, expected 19", last_stall_run);
    end
  endtask

  task automatic test_div_exception();
    int d0;
    bit ok;
    d0 = n_div;
    q.push_back('{5'd30, 1'b1, 32'd5});
    issue(1'b1, 5'd5);
    wait_cycles(10);
    pulse_rdy(1'b1);
    wait_idle(ok);
    checks++;
    if (!ok || n_div - d0 !== 1) begin
      errors++; $display("FAIL div_exc_pulse: got pulses=%0d busy=%0b, expected 1 and 0", n_div - d0, busy);
    end
  endtask

  task automatic test_r0();
    int w0;
    bit ok;
    w0 = n_wb;
    issue(1'b0, 5'd0);
    wait_cycles(4);
    pulse_rdy(1'b0);
    wait_idle(ok);
    checks++;
    if (!ok || n_wb !== w0) begin
      errors++; $display("FAIL r0_no_wb: got writebacks=%0d, expected 0", n_wb - w0);
    end
    q.push_back('{5'd30, 1'b1, 32'd4});
    issue(1'b0, 5'd0);
    wait_cycles(4);
    pulse_rdy(1'b1);
    wait_idle(ok);
    checks++;
    if (!ok || n_wb - w0 !== 1) begin
      errors++; $display("FAIL r0_exc_wb: got writebacks=%0d, expected 1", n_wb - w0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    q.push_back('{5'd30, 1'b1, 32'd5});
    issue(1'b1, 5'd6);
    wait_idle(ok);
    checks++;
    if (!ok || done_cyc - start_cyc !== 38) begin
      errors++; $display("FAIL div_timeout_len: got %0d, expected 38", done_cyc - start_cyc);
    end
    q.push_back('{5'd30, 1'b1, 32'd4});
    issue(1'b0, 5'd2);
    wait_idle(ok);
    checks++;
    if (!ok || done_cyc - start_cyc !== 22) begin
      errors++; $display("FAIL mul_timeout_len: got %0d, expected 22", done_cyc - start_cyc);
    end
  endtask

  task automatic test_flush();
    int w0, m0;
    bit ok;
    w0 = n_wb;
    issue(1'b0, 5'd7);
    wait_cycles(5);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_run_idle: busy=%0b, expected 0", busy); end

    issue(1'b0, 5'd8);
    flush = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl_mult !== 1'b0) begin errors++; $display("FAIL flush_start_pulse: got %0b, expected 0", ctrl_mult); end
    @(posedge clock);
    #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_idle: busy=%0b, expected 0", busy); end

    issue(1'b0, 5'd10);
    wait_cycles(2);
    pulse_rdy(1'b0);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;

    issue(1'b1, 5'd9);
    wait_cycles(3);
    reset = 1'b1;
    #2;
    checks++;
    if ({busy, wb_en, stall, ctrl_div} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_run: got busy=%0b wb_en=%0b stall=%0b cd=%0b, expected 0",
                         busy, wb_en, stall, ctrl_div);
    end
    wait_cycles(1);
    reset = 1'b0;
    checks++;
    if (n_wb !== w0) begin errors++; $display("FAIL flush_no_wb: got %0d writebacks, expected 0", n_wb - w0); end

    m0 = n_mult;
    q.push_back('{5'd4, 1'b0, 32'd0});
    issue(1'b0, 5'd4);
    @(negedge clock);
    checks++;
    if (ctrl_mult !== 1'b1) begin errors++; $display("FAIL post_reset_pulse: got %0b, expected 1", ctrl_mult); end
    @(posedge clock);
    #1;
    wait_cycles(2);
    pulse_rdy(1'b0);
    wait_idle(ok);
    checks++;
    if (!ok || n_mult - m0 !== 1) begin
      errors++; $display("FAIL post_reset_op: got pulses=%0d busy=%0b, expected 1 and 0", n_mult - m0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    bit ok;
    w0 = n_wb; d0 = n_div;
    q.push_back('{5'd11, 1'b0, 32'd0});
    issue(1'b0, 5'd11);
    wait_cycles(3);
    pulse_rdy(1'b0);
    // Present the div already in the DONE cycle; it must wait for IDLE.
    q.push_back('{5'd12, 1'b0, 32'd0});
    issue_valid = 1'b1; opCode = 5'd0; funcode = 5'd7; rd = 5'd12;
    wait_cycles(2);
    issue_valid = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (n_div - d0 !== 1 || start_cyc - done_cyc !== 2) begin
      errors++; $display("FAIL b2b_start_gap: got gap=%0d pulses=%0d, expected 2 and 1",
                         start_cyc - done_cyc, n_div - d0);
    end
    @(posedge clock);
    #1;
    wait_cycles(4);
    pulse_rdy(1'b0);
    wait_idle(ok);
    checks++;
    if (!ok || n_wb - w0 !== 2) begin
      errors++; $display("FAIL b2b_writebacks: got %0d, expected 2", n_wb - w0);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_exception();
    test_r0();
    test_timeout();
    test_flush();
    test_back_to_back();
    wait_cycles(2);
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
